// File: rtl/step_pulse_slave_if.sv
// picorv32 native memory bus as seen by a memory-mapped responder.
interface step_pulse_slave_if;
   logic        mem_valid_in;
   logic [31:0] mem_addr_in;
   logic [31:0] mem_wdata_in;
   logic [3:0]  mem_wstrb_in;
   logic        mem_ready_out;
   logic [31:0] mem_rdata_out;

   modport master (
      output mem_valid_in, mem_addr_in, mem_wdata_in, mem_wstrb_in,
      input  mem_ready_out, mem_rdata_out
   );

   modport slave (
      input  mem_valid_in, mem_addr_in, mem_wdata_in, mem_wstrb_in,
      output mem_ready_out, mem_rdata_out
   );
endinterface

// File: rtl/step_pulse_slave.sv
// Memory-mapped step/direction pulse generator: the CPU loads a half period and a step
// count, then START emits that many STEP pulses with DIR and driver enable alongside.
module step_pulse_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
   parameter int          CNT_W     = 24
) (
   input  logic               clk_in,
   input  logic               reset_n_in,
   step_pulse_slave_if.slave  bus,
   output logic               step_out,
   output logic               dir_out,
   output logic               driver_en_n_out,
   output logic               busy_out
);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d, half_q, steps_q;
   logic             en_q, dir_q, dir_lat_q, done_q;
   logic             ready_q, rd_q;
   logic [1:0]       sel_q;

   logic             hit, acc, wr, idle, wr_ctrl, en_new, dir_new;
   logic             abort_req, start_go, done_w1c, steps_dec, done_set;
   logic [1:0]       sel;
   logic [31:0]      wdata;
   logic [3:0]       wstrb;
   logic [1:0]       unused_addr;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++)
         if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   // HALF = 0 behaves as HALF = 1, so both reload the timer with 0
   function automatic logic [CNT_W-1:0] half_reload(input logic [CNT_W-1:0] h);
      return (h == '0) ? '0 : h - CNT_W'(1);
   endfunction

   assign wdata       = bus.mem_wdata_in;
   assign wstrb       = bus.mem_wstrb_in;
   assign sel         = bus.mem_addr_in[3:2];
   assign unused_addr = bus.mem_addr_in[1:0];

   assign hit      = bus.mem_valid_in && (bus.mem_addr_in[31:4] == BASE_ADDR[31:4]);
   assign acc      = hit && !ready_q;
   assign wr       = acc && (wstrb != 4'b0000);
   assign idle     = (state_q == S_IDLE);
   assign wr_ctrl  = wr && (sel == 2'd0) && wstrb[0];
   assign en_new   = wr_ctrl ? wdata[0] : en_q;
   assign dir_new  = (wr_ctrl && idle) ? wdata[1] : dir_q;
   assign abort_req = !idle && wr_ctrl && (wdata[3] || !wdata[0]);
   assign start_go = idle && wr_ctrl && wdata[2] && !wdata[3] && wdata[0] && (steps_q != '0);
   assign done_w1c = wr && (sel == 2'd3) && wstrb[0] && wdata[1];

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      steps_dec = 1'b0;
      done_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_go) begin
               state_d = S_HIGH;
               tmr_d   = half_reload(half_q);
            end
         end
         S_HIGH: begin
            if (abort_req) begin
               state_d = S_IDLE;
            end else if (tmr_q == '0) begin
               state_d   = S_LOW;
               tmr_d     = half_reload(half_q);
               steps_dec = 1'b1;
            end else begin
               tmr_d = tmr_q - CNT_W'(1);
            end
         end
         S_LOW: begin
            if (abort_req) begin
               state_d = S_IDLE;
            end else if (tmr_q == '0) begin
               if (steps_q != '0) begin
                  state_d = S_HIGH;
                  tmr_d   = half_reload(half_q);
               end else begin
                  state_d  = S_IDLE;
                  done_set = 1'b1;
               end
            end else begin
               tmr_d = tmr_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         half_q    <= '0;
         steps_q   <= '0;
         en_q      <= 1'b0;
         dir_q     <= 1'b0;
         dir_lat_q <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
         rd_q      <= 1'b0;
         sel_q     <= 2'd0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         ready_q <= acc;
         rd_q    <= acc && (wstrb == 4'b0000);
         if (acc) sel_q <= sel;
         en_q    <= en_new;
         dir_q   <= dir_new;
         if (start_go) dir_lat_q <= dir_new;
         if (wr && (sel == 2'd1) && idle)
            half_q <= CNT_W'(merge_bytes(32'(half_q), wdata, wstrb));
         // Decrement and CPU load are exclusive: loads are only accepted while idle
         if (steps_dec && (steps_q != '0))
            steps_q <= steps_q - CNT_W'(1);
         else if (wr && (sel == 2'd2) && idle)
            steps_q <= CNT_W'(merge_bytes(32'(steps_q), wdata, wstrb));
         if (done_set)
            done_q <= 1'b1;
         else if (start_go || done_w1c)
            done_q <= 1'b0;
      end
   end

   always_comb begin
      bus.mem_rdata_out = '0;
      if (ready_q && rd_q) begin
         case (sel_q)
            2'd0:    bus.mem_rdata_out = {30'b0, dir_q, en_q};
            2'd1:    bus.mem_rdata_out = 32'(half_q);
            2'd2:    bus.mem_rdata_out = 32'(steps_q);
            default: bus.mem_rdata_out = {30'b0, done_q, !idle};
         endcase
      end
   end

   assign bus.mem_ready_out = ready_q;
   assign step_out          = (state_q == S_HIGH);
   assign dir_out           = dir_lat_q;
   assign driver_en_n_out   = ~en_q;
   assign busy_out          = !idle;

endmodule

// File: tb/tb_step_pulse_slave.sv
// Bench for step_pulse_slave: register vector table, hand-written burst/abort sequences
// and randomized bursts checked against a closed-form waveform model.
module tb_step_pulse_slave;
   localparam logic [31:0] BASE = 32'h2000_0000;

   logic clk_in = 1'b0;
   logic reset_n_in;
   logic step_out, dir_out, driver_en_n_out, busy_out;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic [31:0] xfer_rdata;
   int   xfer_lat;

   step_pulse_slave_if bus();

   step_pulse_slave #(.BASE_ADDR(BASE), .CNT_W(24)) dut (
      .clk_in          (clk_in),
      .reset_n_in      (reset_n_in),
      .bus             (bus),
      .step_out        (step_out),
      .dir_out         (dir_out),
      .driver_en_n_out (driver_en_n_out),
      .busy_out        (busy_out)
   );

   always #20 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic xfer(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
      if (bus.mem_ready_out) tick(1);
      bus.mem_valid_in = 1'b1;
      bus.mem_addr_in  = addr;
      bus.mem_wdata_in = d;
      bus.mem_wstrb_in = s;
      xfer_lat = 0;
      do begin
         tick(1);
         xfer_lat++;
      end while (!bus.mem_ready_out && xfer_lat < 16);
      check("ack_seen", {31'b0, bus.mem_ready_out}, 32'd1);
      xfer_rdata = bus.mem_rdata_out;
      bus.mem_valid_in = 1'b0;
      bus.mem_wstrb_in = 4'b0000;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
      xfer(BASE | {28'b0, off}, d, s);
   endtask

   task automatic rd_check(input string name, input logic [3:0] off, input logic [31:0] exp);
      xfer(BASE | {28'b0, off}, 32'h0, 4'h0);
      check(name, xfer_rdata, exp);
   endtask

   // Reference: pulse k of a burst (k counted from the START ack edge) is high while
   // floor(k/H) is even, for 2*N*H cycles in total.
   task automatic run_burst(input int n, input int h, input logic d, input string tag);
      int he, total;
      logic exp_step, exp_busy;
      he = (h == 0) ? 1 : h;
      total = 2 * n * he;
      wr(4'h4, h);
      wr(4'h8, n);
      wr(4'h0, 32'h5 | {30'b0, d, 1'b0});
      for (int k = 0; k < total + 2; k++) begin
         exp_busy = (k < total);
         exp_step = exp_busy && (((k / he) % 2) == 0);
         check({tag, "_wave"}, {29'b0, step_out, busy_out, dir_out}, {29'b0, exp_step, exp_busy, d});
         tick(1);
      end
      rd_check({tag, "_status_done"}, 4'hC, 32'h2);
      rd_check({tag, "_steps_zero"}, 4'h8, 32'h0);
   endtask

   typedef struct {
      logic [3:0]  off;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[16];
   int   guard;
   int   t0;

   initial begin
      reset_n_in       = 1'b0;
      bus.mem_valid_in = 1'b0;
      bus.mem_addr_in  = 32'h0;
      bus.mem_wdata_in = 32'h0;
      bus.mem_wstrb_in = 4'h0;

      vecs[0]  = '{4'h0, 32'h0,        4'h0, 32'h0};
      vecs[1]  = '{4'h4, 32'h0,        4'h0, 32'h0};
      vecs[2]  = '{4'h8, 32'h0,        4'h0, 32'h0};
      vecs[3]  = '{4'hC, 32'h0,        4'h0, 32'h0};
      vecs[4]  = '{4'h4, 32'h00123456, 4'hF, 32'h0};
      vecs[5]  = '{4'h4, 32'h0,        4'h0, 32'h00123456};
      vecs[6]  = '{4'h4, 32'hFFFFFFFF, 4'h1, 32'h0};
      vecs[7]  = '{4'h4, 32'h0,        4'h0, 32'h001234FF};
      vecs[8]  = '{4'h4, 32'h0,        4'hF, 32'h0};
      vecs[9]  = '{4'h4, 32'hFFFFFFFF, 4'h1, 32'h0};
      vecs[10] = '{4'h4, 32'h0,        4'h0, 32'h000000FF};
      vecs[11] = '{4'h8, 32'h01000005, 4'hF, 32'h0};
      vecs[12] = '{4'h8, 32'hAABBCCDD, 4'h4, 32'h0};
      vecs[13] = '{4'h8, 32'h0,        4'h0, 32'h00BB0005};
      vecs[14] = '{4'h0, 32'h0000000B, 4'hF, 32'h0};
      vecs[15] = '{4'h0, 32'h0,        4'h0, 32'h00000003};

      // Reset state
      tick(3);
      check("rst_pins", {28'b0, step_out, dir_out, driver_en_n_out, busy_out}, 32'h2);
      check("rst_ready", {31'b0, bus.mem_ready_out}, 32'h0);
      reset_n_in = 1'b1;
      tick(2);
      check("rst_rdata", bus.mem_rdata_out, 32'h0);

      // Register vector table
      for (int i = 0; i < 16; i++) begin
         xfer(BASE | {28'b0, vecs[i].off}, vecs[i].wdata, vecs[i].wstrb);
         check($sformatf("vec%0d_latency", i), xfer_lat, 32'd1);
         if (vecs[i].wstrb == 4'h0)
            check($sformatf("vec%0d_rdata", i), xfer_rdata, vecs[i].exp);
      end
      check("en_drives_pin", {31'b0, driver_en_n_out}, 32'h0);
      tick(1);
      check("rdata_zero_after_ack", bus.mem_rdata_out, 32'h0);
      wr(4'h0, 32'h0);
      check("en_cleared_pin", {31'b0, driver_en_n_out}, 32'h1);

      // Basic bursts, then DONE clear
      run_burst(4, 3, 1'b0, "h3n4");
      run_burst(2, 0, 1'b1, "h0n2");
      wr(4'hC, 32'h2);
      rd_check("done_w1c", 4'hC, 32'h0);

      // STOP after the third falling edge
      wr(4'h4, 5);
      wr(4'h8, 10);
      wr(4'h0, 32'h5);
      tick(25);
      check("stop_pre_low", {31'b0, step_out}, 32'h0);
      wr(4'h0, 32'h9);
      check("stop_pins", {30'b0, step_out, busy_out}, 32'h0);
      check("stop_en_kept", {31'b0, driver_en_n_out}, 32'h0);
      rd_check("stop_steps_left", 4'h8, 32'd7);
      rd_check("stop_no_done", 4'hC, 32'h0);

      // EN=0 abort in the high phase
      wr(4'h4, 4);
      wr(4'h8, 5);
      wr(4'h0, 32'h5);
      tick(1);
      check("en_abort_pre", {30'b0, step_out, busy_out}, 32'h3);
      wr(4'h0, 32'h0);
      check("en_abort_pins", {29'b0, step_out, busy_out, driver_en_n_out}, 32'h1);
      rd_check("en_abort_steps", 4'h8, 32'd5);
      rd_check("en_abort_no_done", 4'hC, 32'h0);
      wr(4'h0, 32'hD);
      tick(1);
      check("stop_beats_start", {31'b0, busy_out}, 32'h0);

      // Writes while busy are ignored
      wr(4'h4, 2);
      wr(4'h8, 3);
      wr(4'h0, 32'h7);
      t0 = cyc;
      wr(4'h0, 32'h1);
      wr(4'h8, 50);
      wr(4'h4, 7);
      wr(4'h0, 32'h5);
      check("busy_dir_held", {31'b0, dir_out}, 32'h1);
      guard = 0;
      while (busy_out && guard < 200) begin
         tick(1);
         guard++;
      end
      check("busy_length", cyc - t0, 32'd12);
      check("busy_dir_end", {31'b0, dir_out}, 32'h1);
      rd_check("busy_steps", 4'h8, 32'h0);
      rd_check("busy_half", 4'h4, 32'h2);
      rd_check("busy_ctrl", 4'h0, 32'h3);
      wr(4'hC, 32'h2);
      wr(4'h0, 32'h5);
      tick(1);
      check("start_steps0", {31'b0, busy_out}, 32'h0);
      rd_check("start_steps0_status", 4'hC, 32'h0);
      wr(4'h8, 3);
      wr(4'h0, 32'h4);
      tick(1);
      check("start_en0", {30'b0, busy_out, driver_en_n_out}, 32'h1);
      rd_check("start_en0_status", 4'hC, 32'h0);
      rd_check("start_en0_steps", 4'h8, 32'd3);

      // Off-window accesses
      bus.mem_valid_in = 1'b1;
      bus.mem_addr_in  = BASE + 32'h14;
      bus.mem_wdata_in = 32'h77;
      bus.mem_wstrb_in = 4'hF;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("offwin_ready", {31'b0, bus.mem_ready_out}, 32'h0);
         check("offwin_rdata", bus.mem_rdata_out, 32'h0);
      end
      bus.mem_addr_in  = 32'h3000_0004;
      bus.mem_wstrb_in = 4'h0;
      tick(2);
      check("offwin2_ready", {31'b0, bus.mem_ready_out}, 32'h0);
      bus.mem_valid_in = 1'b0;
      rd_check("offwin_half_kept", 4'h4, 32'h2);

      // Randomized bursts
      for (int i = 0; i < 6; i++)
         run_burst(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), "rand");

      // Asynchronous reset mid-burst
      wr(4'h4, 3);
      wr(4'h8, 4);
      wr(4'h0, 32'h7);
      tick(1);
      #5 reset_n_in = 1'b0;
      #1;
      check("async_rst_pins", {28'b0, step_out, dir_out, driver_en_n_out, busy_out}, 32'h2);
      tick(1);
      reset_n_in = 1'b1;
      tick(1);
      rd_check("async_rst_steps", 4'h8, 32'h0);
      rd_check("async_rst_half", 4'h4, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
